// File: rtl/branch_predict_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_tracker_pkg
// Purpose  : Shared defaults and entry layout for the branch prediction tracker.
// Revision : 1.0 - initial release
// ============================================================================
package branch_predict_tracker_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DEPTH_DEFAULT  = 4;
    localparam int CNT_W_DEFAULT  = 16;

    // Field order matches the packed vector stored in the FIFO: {pc, taken, target}
    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] pc;
        logic                      taken;
        logic [ADDR_W_DEFAULT-1:0] target;
    } predict_entry_t;

    localparam int ENTRY_W_DEFAULT = $bits(predict_entry_t);

endpackage
`default_nettype wire

// File: rtl/branch_predict_tracker_predict_fifo.sv
`default_nettype none
// ============================================================================
// Module   : predict_fifo
// Purpose  : Synchronous FIFO with push, pop and flush; flush beats push/pop.
// Revision : 1.0 - initial release
// ============================================================================
module predict_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign full      = (r_count == C_DEPTH);
    assign empty     = (r_count == '0);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push_ok && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predict_tracker.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_tracker
// Purpose  : Tracks in-flight predictions, checks them at resolve, and drives
//            redirect/flush and predictor training.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_tracker
    import branch_predict_tracker_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     fetch_valid,
    input  logic [ADDR_W-1:0]        fetch_pc,
    output logic                     fetch_ready,
    output logic [ADDR_W-1:0]        next_pc,
    output logic [ADDR_W-1:0]        pred_current_pc,
    input  logic                     pred_taken,
    input  logic [ADDR_W-1:0]        pred_target,
    input  logic                     resolve_valid,
    input  logic                     resolve_is_branch,
    input  logic                     resolve_taken,
    input  logic [ADDR_W-1:0]        resolve_target,
    output logic                     mispredict,
    output logic [ADDR_W-1:0]        redirect_pc,
    output logic                     update_valid,
    output logic [ADDR_W-1:0]        update_pc,
    output logic                     update_taken,
    output logic [ADDR_W-1:0]        update_target,
    output logic [$clog2(DEPTH):0]   inflight_count,
    output logic [CNT_W-1:0]         mispredict_count,
    output logic                     underflow_err
);

    localparam int          ENTRY_W = 2 * ADDR_W + 1;
    localparam logic [ADDR_W-1:0] C_INSN_BYTES = ADDR_W'(4);

    logic [ENTRY_W-1:0]      w_push_data;
    logic [ENTRY_W-1:0]      w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_flush;
    logic                    w_wrong;
    logic [ADDR_W-1:0]       w_correct_pc;
    logic [ADDR_W-1:0]       w_e_pc;
    logic                    w_e_taken;
    logic [ADDR_W-1:0]       w_e_target;

    logic                    r_mispredict;
    logic [ADDR_W-1:0]       r_redirect_pc;
    logic                    r_update_valid;
    logic [ADDR_W-1:0]       r_update_pc;
    logic                    r_update_taken;
    logic [ADDR_W-1:0]       r_update_target;
    logic [CNT_W-1:0]        r_mispredict_count;
    logic                    r_underflow_err;

    assign pred_current_pc = fetch_pc;
    assign next_pc         = pred_taken ? pred_target : fetch_pc + C_INSN_BYTES;
    assign fetch_ready     = !w_full && !r_mispredict;

    assign w_push      = fetch_valid && fetch_ready;
    assign w_pop       = resolve_valid && !w_empty;
    assign w_push_data = {fetch_pc, pred_taken, pred_target};

    predict_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (w_flush),
        .head      (w_head),
        .count     (inflight_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign w_e_pc     = w_head[ENTRY_W-1 -: ADDR_W];
    assign w_e_taken  = w_head[ADDR_W];
    assign w_e_target = w_head[ADDR_W-1:0];

    // A non-branch predicted taken sent fetch down a bogus path.
    always_comb begin
        w_wrong = w_e_taken;
        if (resolve_is_branch) begin
            w_wrong = (w_e_taken != resolve_taken) ||
                      (resolve_taken && (w_e_target != resolve_target));
        end
    end

    assign w_correct_pc = (resolve_taken && resolve_is_branch) ? resolve_target
                                                               : w_e_pc + C_INSN_BYTES;
    assign w_flush      = w_pop && w_wrong;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mispredict       <= 1'b0;
            r_redirect_pc      <= '0;
            r_update_valid     <= 1'b0;
            r_update_pc        <= '0;
            r_update_taken     <= 1'b0;
            r_update_target    <= '0;
            r_mispredict_count <= '0;
            r_underflow_err    <= 1'b0;
        end else begin
            r_mispredict   <= w_flush;
            r_update_valid <= w_pop && resolve_is_branch;
            if (w_flush) begin
                r_redirect_pc <= w_correct_pc;
            end
            if (w_pop && resolve_is_branch) begin
                r_update_pc     <= w_e_pc;
                r_update_taken  <= resolve_taken;
                r_update_target <= resolve_target;
            end
            if (w_flush && (r_mispredict_count != '1)) begin
                r_mispredict_count <= r_mispredict_count + CNT_W'(1);
            end
            if (resolve_valid && w_empty) begin
                r_underflow_err <= 1'b1;
            end
        end
    end

    assign mispredict       = r_mispredict;
    assign redirect_pc      = r_redirect_pc;
    assign update_valid     = r_update_valid;
    assign update_pc        = r_update_pc;
    assign update_taken     = r_update_taken;
    assign update_target    = r_update_target;
    assign mispredict_count = r_mispredict_count;
    assign underflow_err    = r_underflow_err;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_tracker
// Purpose  : Directed self-checking bench for branch_predict_tracker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_tracker;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 2;

    logic              CLK;
    logic              nRST;
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_ready;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] pred_current_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              resolve_valid;
    logic              resolve_is_branch;
    logic              resolve_taken;
    logic [ADDR_W-1:0] resolve_target;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;
    logic              update_valid;
    logic [ADDR_W-1:0] update_pc;
    logic              update_taken;
    logic [ADDR_W-1:0] update_target;
    logic [2:0]        inflight_count;
    logic [CNT_W-1:0]  mispredict_count;
    logic              underflow_err;

    int n_cmp = 0;
    int n_err = 0;

    branch_predict_tracker #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_ready       (fetch_ready),
        .next_pc           (next_pc),
        .pred_current_pc   (pred_current_pc),
        .pred_taken        (pred_taken),
        .pred_target       (pred_target),
        .resolve_valid     (resolve_valid),
        .resolve_is_branch (resolve_is_branch),
        .resolve_taken     (resolve_taken),
        .resolve_target    (resolve_target),
        .mispredict        (mispredict),
        .redirect_pc       (redirect_pc),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .inflight_count    (inflight_count),
        .mispredict_count  (mispredict_count),
        .underflow_err     (underflow_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        fetch_valid = v;
        fetch_pc    = pc;
        pred_taken  = tk;
        pred_target = tgt;
    endtask

    task automatic resolve(input logic v, input logic br, input logic tk, input logic [31:0] tgt);
        resolve_valid     = v;
        resolve_is_branch = br;
        resolve_taken     = tk;
        resolve_target    = tgt;
    endtask

    initial begin
        nRST = 1'b0;
        fetch(1'b0, 32'h0, 1'b0, 32'h0);
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
        #3;
        chk("rst_inflight", 64'(inflight_count), 64'd0);
        chk("rst_mispredict", 64'(mispredict), 64'd0);
        chk("rst_update_valid", 64'(update_valid), 64'd0);
        chk("rst_underflow", 64'(underflow_err), 64'd0);
        chk("rst_mcount", 64'(mispredict_count), 64'd0);
        chk("rst_redirect", 64'(redirect_pc), 64'd0);
        chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        #9;
        nRST = 1'b1;
        tick();

        // Correctly predicted not-taken branch
        fetch(1'b1, 32'h100, 1'b0, 32'h0);
        #1;
        chk("t1_next_pc", 64'(next_pc), 64'h104);
        chk("t1_pred_pc", 64'(pred_current_pc), 64'h100);
        tick();
        fetch(1'b0, 32'h0, 1'b0, 32'h0);
        chk("t1_inflight", 64'(inflight_count), 64'd1);
        resolve(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t1_mispredict", 64'(mispredict), 64'd0);
        chk("t1_update_valid", 64'(update_valid), 64'd1);
        chk("t1_update_pc", 64'(update_pc), 64'h100);
        chk("t1_update_taken", 64'(update_taken), 64'd0);
        chk("t1_inflight_after", 64'(inflight_count), 64'd0);
        tick();
        chk("t1_update_pulse", 64'(update_valid), 64'd0);

        // Direction mispredict
        fetch(1'b1, 32'h200, 1'b0, 32'h0);
        tick();
        fetch(1'b0, 32'h0, 1'b0, 32'h0);
        resolve(1'b1, 1'b1, 1'b1, 32'h300);
        tick();
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t2_mispredict", 64'(mispredict), 64'd1);
        chk("t2_redirect", 64'(redirect_pc), 64'h300);
        chk("t2_inflight", 64'(inflight_count), 64'd0);
        chk("t2_mcount", 64'(mispredict_count), 64'd1);
        chk("t2_fetch_ready", 64'(fetch_ready), 64'd0);
        chk("t2_update_taken", 64'(update_taken), 64'd1);
        tick();
        chk("t2_mispredict_pulse", 64'(mispredict), 64'd0);
        chk("t2_fetch_ready_back", 64'(fetch_ready), 64'd1);

        // Target mispredict
        fetch(1'b1, 32'h380, 1'b1, 32'h400);
        #1;
        chk("t3_next_pc", 64'(next_pc), 64'h400);
        tick();
        fetch(1'b0, 32'h0, 1'b0, 32'h0);
        resolve(1'b1, 1'b1, 1'b1, 32'h480);
        tick();
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t3_mispredict", 64'(mispredict), 64'd1);
        chk("t3_redirect", 64'(redirect_pc), 64'h480);
        chk("t3_update_target", 64'(update_target), 64'h480);
        chk("t3_update_pc", 64'(update_pc), 64'h380);
        chk("t3_mcount", 64'(mispredict_count), 64'd2);
        tick();

        // Non-branch predicted taken: redirect to pc+4, no training pulse
        fetch(1'b1, 32'h500, 1'b1, 32'h600);
        tick();
        fetch(1'b0, 32'h0, 1'b0, 32'h0);
        resolve(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4_mispredict", 64'(mispredict), 64'd1);
        chk("t4_redirect", 64'(redirect_pc), 64'h504);
        chk("t4_update_valid", 64'(update_valid), 64'd0);
        chk("t4_mcount", 64'(mispredict_count), 64'd3);
        tick();

        // Fill to DEPTH with no resolves
        for (int i = 0; i < 4; i++) begin
            fetch(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 32'h0);
            tick();
        end
        chk("t5_inflight_full", 64'(inflight_count), 64'd4);
        chk("t5_fetch_ready_full", 64'(fetch_ready), 64'd0);
        fetch(1'b1, 32'h1010, 1'b0, 32'h0);
        tick();
        chk("t5_no_fifth_push", 64'(inflight_count), 64'd4);
        // Resolve while full: fetch_ready is low, so only the pop happens
        resolve(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("t5_full_pop_count", 64'(inflight_count), 64'd3);
        chk("t5_full_pop_pc", 64'(update_pc), 64'h1000);
        // Now push and pop together: occupancy unchanged
        tick();
        chk("t5_pushpop_count", 64'(inflight_count), 64'd3);
        chk("t5_pushpop_pc", 64'(update_pc), 64'h1004);
        chk("t5_pushpop_nomisp", 64'(mispredict), 64'd0);

        // Flush race: mispredict with a simultaneous fetch, 3 entries queued
        fetch(1'b1, 32'h1014, 1'b0, 32'h0);
        resolve(1'b1, 1'b1, 1'b1, 32'h2000);
        #1;
        chk("t6_ready_before", 64'(fetch_ready), 64'd1);
        tick();
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t6_inflight", 64'(inflight_count), 64'd0);
        chk("t6_mispredict", 64'(mispredict), 64'd1);
        chk("t6_fetch_ready", 64'(fetch_ready), 64'd0);
        chk("t6_redirect", 64'(redirect_pc), 64'h2000);
        chk("t6_update_pc", 64'(update_pc), 64'h1008);
        chk("t6_mcount_sat", 64'(mispredict_count), 64'd3);
        tick();
        fetch(1'b0, 32'h0, 1'b0, 32'h0);
        chk("t6_no_push_in_n1", 64'(inflight_count), 64'd0);

        // Resolve with empty FIFO
        resolve(1'b1, 1'b1, 1'b1, 32'h3333);
        tick();
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t7_underflow", 64'(underflow_err), 64'd1);
        chk("t7_no_mispredict", 64'(mispredict), 64'd0);
        chk("t7_no_update", 64'(update_valid), 64'd0);
        chk("t7_inflight", 64'(inflight_count), 64'd0);
        tick();
        chk("t7_underflow_sticky", 64'(underflow_err), 64'd1);

        // Reset mid-stream
        fetch(1'b1, 32'h3000, 1'b0, 32'h0);
        tick();
        fetch(1'b1, 32'h3004, 1'b0, 32'h0);
        tick();
        fetch(1'b0, 32'h0, 1'b0, 32'h0);
        resolve(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t8_pre_update_valid", 64'(update_valid), 64'd1);
        chk("t8_pre_inflight", 64'(inflight_count), 64'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("t8_update_valid", 64'(update_valid), 64'd0);
        chk("t8_update_pc", 64'(update_pc), 64'd0);
        chk("t8_inflight", 64'(inflight_count), 64'd0);
        chk("t8_underflow", 64'(underflow_err), 64'd0);
        chk("t8_mcount", 64'(mispredict_count), 64'd0);
        chk("t8_redirect", 64'(redirect_pc), 64'd0);
        chk("t8_update_target", 64'(update_target), 64'd0);
        #1;
        nRST = 1'b1;
        tick();
        chk("t8_after_release", 64'(inflight_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
